// File: rtl/sparse_mac_row.sv
// sparse_mac_row
//   Sparse multiply-accumulate engine for one PE row. Each block is one output
//   location across all channels. The activation and weight sparsity flags are
//   ANDed, one operand fetch is issued per matched channel, the signed products
//   are accumulated, and one partial sum is emitted per block. Completion of
//   the row is reported with a single-cycle row_done pulse.
//
//   Optional feature macro: SPARSE_MAC_SAT_EN
//     defined   -> every accumulate saturates to the signed PSUM_WIDTH range.
//                  A sticky per-block clamp flag is kept.
//     undefined -> plain two's-complement wrap.
//
// Ports
//   clk, rst_n                  clock, async active-low reset
//   row_start                   begin (or restart) a row; wins in every state
//   row_act_base, wei_col       row act base address and kernel column
//   row_done                    registered one-cycle pulse after last psum
//   flg_val/flg_rdy, flg_act/flg_wei   per-block sparsity flag pair
//   op_req, op_act_addr, op_wei_addr   operand fetch request
//   op_val, op_act, op_wei             operand return (answers op_req)
//   psum_val/psum_rdy, psum_addr, psum_data   partial sum output
module sparse_mac_row #(
  parameter int DATA_WIDTH      = 8,
  parameter int BLOCK_DEPTH     = 32,
  parameter int PSUM_WIDTH      = 24,
  parameter int PSUM_ADDR_WIDTH = 5,
  parameter int ACT_ADDR_WIDTH  = 6,
  parameter int WEI_ADDR_WIDTH  = 6,
  parameter int ROW_BLOCKS      = 16,
  parameter int KERNEL_COLS     = 3
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               row_start,
  input  logic [ACT_ADDR_WIDTH-1:0]          row_act_base,
  input  logic [1:0]                         wei_col,
  output logic                               row_done,
  input  logic                               flg_val,
  output logic                               flg_rdy,
  input  logic [BLOCK_DEPTH-1:0]             flg_act,
  input  logic [BLOCK_DEPTH-1:0]             flg_wei,
  output logic                               op_req,
  output logic [ACT_ADDR_WIDTH-1:0]          op_act_addr,
  output logic [WEI_ADDR_WIDTH-1:0]          op_wei_addr,
  input  logic                               op_val,
  input  logic signed [DATA_WIDTH-1:0]       op_act,
  input  logic signed [DATA_WIDTH-1:0]       op_wei,
  output logic                               psum_val,
  input  logic                               psum_rdy,
  output logic [PSUM_ADDR_WIDTH-1:0]         psum_addr,
  output logic signed [PSUM_WIDTH-1:0]       psum_data
);

  localparam int PC_W  = $clog2(BLOCK_DEPTH + 1);
  localparam int CNT_W = (ROW_BLOCKS > 1) ? $clog2(ROW_BLOCKS) : 1;
  localparam logic [PSUM_ADDR_WIDTH-1:0] ADDR_CTR = PSUM_ADDR_WIDTH'((KERNEL_COLS - 1) / 2);
  localparam logic [CNT_W-1:0]           CNT_LAST = CNT_W'(ROW_BLOCKS - 1);

  typedef enum logic [1:0] {IDLE, WAIT, SCAN, OUT} state_t;

  state_t                      state, state_nxt;
  logic signed [PSUM_WIDTH-1:0] acc, acc_nxt;
  logic [CNT_W-1:0]            block_cnt;
  logic [ACT_ADDR_WIDTH-1:0]   act_blk_base;
  logic [BLOCK_DEPTH-1:0]      fa, fw, match;
  logic [BLOCK_DEPTH-1:0]      lowbit, below, match_rest;
  logic                        last_blk;

  function automatic logic [PC_W-1:0] popcnt(input logic [BLOCK_DEPTH-1:0] v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int k = 0; k < BLOCK_DEPTH; k++) c = c + PC_W'(v[k]);
    return c;
  endfunction

  // Lowest pending match isolated as a one-hot; 'below' masks channels under it,
  // whose flag popcounts give the dense register-file offsets.
  assign lowbit     = match & (~match + 1'b1);
  assign below      = lowbit - 1'b1;
  assign match_rest = match & ~lowbit;
  assign last_blk   = (block_cnt == CNT_LAST);

  assign flg_rdy     = (state == WAIT);
  assign op_req      = (state == SCAN);
  assign psum_val    = (state == OUT);
  assign psum_data   = acc;
  assign op_act_addr = op_req ? act_blk_base + ACT_ADDR_WIDTH'(popcnt(fa & below)) : '0;
  assign op_wei_addr = op_req ? WEI_ADDR_WIDTH'(popcnt(fw & below)) : '0;

  // Product sign-extended to the accumulator width.
  logic signed [2*DATA_WIDTH-1:0] act_ext, wei_ext, prod;
  logic signed [PSUM_WIDTH-1:0]   prod_ext;
  assign act_ext  = (2*DATA_WIDTH)'(op_act);
  assign wei_ext  = (2*DATA_WIDTH)'(op_wei);
  assign prod     = act_ext * wei_ext;
  assign prod_ext = PSUM_WIDTH'(prod);

`ifdef SPARSE_MAC_SAT_EN
  localparam logic signed [PSUM_WIDTH-1:0] ACC_MAX = {1'b0, {(PSUM_WIDTH-1){1'b1}}};
  localparam logic signed [PSUM_WIDTH-1:0] ACC_MIN = {1'b1, {(PSUM_WIDTH-1){1'b0}}};
  logic [PSUM_WIDTH:0] sum;
  logic                clamp, sat_hit;
  assign sum   = {acc[PSUM_WIDTH-1], acc} + {prod_ext[PSUM_WIDTH-1], prod_ext};
  // Overflow when the extra sign bit disagrees with the top result bit.
  assign clamp = sum[PSUM_WIDTH] ^ sum[PSUM_WIDTH-1];
  always_comb begin
    acc_nxt = sum[PSUM_WIDTH-1:0];
    if (clamp) acc_nxt = sum[PSUM_WIDTH] ? ACC_MIN : ACC_MAX;
  end
`else
  assign acc_nxt = acc + prod_ext;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (row_start) state_nxt = WAIT;
    else begin
      case (state)
        WAIT: if (flg_val) state_nxt = ((flg_act & flg_wei) == '0) ? OUT : SCAN;
        SCAN: if (op_val && match_rest == '0) state_nxt = OUT;
        OUT:  if (psum_rdy) state_nxt = last_blk ? IDLE : WAIT;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc          <= '0;
      block_cnt    <= '0;
      act_blk_base <= '0;
      psum_addr    <= '0;
      fa           <= '0;
      fw           <= '0;
      match        <= '0;
      row_done     <= 1'b0;
`ifdef SPARSE_MAC_SAT_EN
      sat_hit      <= 1'b0;
`endif
    end else begin
      row_done <= 1'b0;
      if (row_start) begin
        acc          <= '0;
        block_cnt    <= '0;
        match        <= '0;
        act_blk_base <= row_act_base;
        psum_addr    <= ADDR_CTR - PSUM_ADDR_WIDTH'(wei_col);
`ifdef SPARSE_MAC_SAT_EN
        sat_hit      <= 1'b0;
`endif
      end else begin
        case (state)
          WAIT: if (flg_val) begin
            fa    <= flg_act;
            fw    <= flg_wei;
            match <= flg_act & flg_wei;
            acc   <= '0;
`ifdef SPARSE_MAC_SAT_EN
            sat_hit <= 1'b0;
`endif
          end
          SCAN: if (op_val) begin
            acc   <= acc_nxt;
            match <= match_rest;
`ifdef SPARSE_MAC_SAT_EN
            sat_hit <= sat_hit | clamp;
`endif
          end
          OUT: if (psum_rdy) begin
            psum_addr    <= psum_addr + 1'b1;
            act_blk_base <= act_blk_base + ACT_ADDR_WIDTH'(popcnt(fa));
            block_cnt    <= block_cnt + 1'b1;
            row_done     <= last_blk;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sparse_mac_row.sv
module tb_sparse_mac_row;
  localparam int DW = 8, BD = 32, PW = 24, PAW = 5, AAW = 6, WAW = 6, RB = 16, KC = 3;
  localparam int OPW = 16;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                 row_start = 0, row_done, flg_val = 0, flg_rdy, op_req, op_val = 0;
  logic                 psum_val, psum_rdy = 0;
  logic [AAW-1:0]       row_act_base = 0, op_act_addr;
  logic [1:0]           wei_col = 0;
  logic [BD-1:0]        flg_act = 0, flg_wei = 0;
  logic [WAW-1:0]       op_wei_addr;
  logic signed [DW-1:0] op_act = 0, op_wei = 0;
  logic [PAW-1:0]       psum_addr;
  logic signed [PW-1:0] psum_data;

  sparse_mac_row u_dut (
    .clk(clk), .rst_n(rst_n), .row_start(row_start), .row_act_base(row_act_base),
    .wei_col(wei_col), .row_done(row_done), .flg_val(flg_val), .flg_rdy(flg_rdy),
    .flg_act(flg_act), .flg_wei(flg_wei), .op_req(op_req), .op_act_addr(op_act_addr),
    .op_wei_addr(op_wei_addr), .op_val(op_val), .op_act(op_act), .op_wei(op_wei),
    .psum_val(psum_val), .psum_rdy(psum_rdy), .psum_addr(psum_addr), .psum_data(psum_data)
  );

  // Narrow-accumulator instance for the overflow case.
  logic                  o_row_start = 0, o_row_done, o_flg_val = 0, o_flg_rdy, o_op_req;
  logic                  o_psum_val, o_psum_rdy = 0;
  logic [AAW-1:0]        o_op_act_addr;
  logic [WAW-1:0]        o_op_wei_addr;
  logic [PAW-1:0]        o_psum_addr;
  logic signed [OPW-1:0] o_psum_data;

  sparse_mac_row #(.PSUM_WIDTH(OPW), .ROW_BLOCKS(1)) u_ovf (
    .clk(clk), .rst_n(rst_n), .row_start(o_row_start), .row_act_base(6'd0),
    .wei_col(2'd0), .row_done(o_row_done), .flg_val(o_flg_val), .flg_rdy(o_flg_rdy),
    .flg_act({BD{1'b1}}), .flg_wei({BD{1'b1}}), .op_req(o_op_req), .op_act_addr(o_op_act_addr),
    .op_wei_addr(o_op_wei_addr), .op_val(1'b1), .op_act(8'sd127), .op_wei(8'sd127),
    .psum_val(o_psum_val), .psum_rdy(o_psum_rdy), .psum_addr(o_psum_addr), .psum_data(o_psum_data)
  );

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  // Reference model state: row-level bookkeeping in plain integers.
  int     m_base, m_addr, m_cnt;
  int     ops_q[$];
  int     req_act_q[$], req_wei_q[$];
  longint last_psum;
  int     last_addr;

  function automatic int pc_below(input logic [BD-1:0] v, input int n);
    int c = 0;
    for (int k = 0; k < n; k++) c += int'(v[k]);
    return c;
  endfunction

  task automatic start_row(input int base, input int col);
    row_start = 1; row_act_base = AAW'(base); wei_col = 2'(col);
    @(negedge clk);
    row_start = 0;
    m_base = base % 64;
    m_addr = ((KC - 1) / 2 - col) & ((1 << PAW) - 1);
    m_cnt  = 0;
    chk("start_flg_rdy", flg_rdy, 1);
    chk("start_psum_addr", psum_addr, m_addr);
  endtask

  task automatic run_block(input logic [BD-1:0] fa, input logic [BD-1:0] fw,
                           input bit stall, input int bp);
    longint acc, e;
    int lim;
    logic signed [DW-1:0] a, w;
    req_act_q.delete(); req_wei_q.delete();
    lim = 0;
    while (!flg_rdy && lim < 20) begin @(negedge clk); lim++; end
    chk("flg_rdy", flg_rdy, 1);
    flg_val = 1; flg_act = fa; flg_wei = fw;
    @(negedge clk);
    flg_val = 0; flg_act = $urandom; flg_wei = $urandom;
    acc = 0;
    for (int i = 0; i < BD; i++) begin
      if (fa[i] && fw[i]) begin
        bit done = 0;
        int n = 0;
        while (!done) begin
          chk("op_req", op_req, 1);
          chk("op_act_addr", op_act_addr, (m_base + pc_below(fa, i)) % 64);
          chk("op_wei_addr", op_wei_addr, pc_below(fw, i));
          op_val = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
          if (op_val && ops_q.size() >= 2) begin
            a = DW'(ops_q.pop_front()); w = DW'(ops_q.pop_front());
          end else begin
            a = DW'($urandom); w = DW'($urandom);
          end
          op_act = a; op_wei = w;
          if (op_val) begin
            acc += longint'(a) * longint'(w);
            req_act_q.push_back(int'(op_act_addr));
            req_wei_q.push_back(int'(op_wei_addr));
            done = 1;
          end
          @(negedge clk);
          n++;
          if (!done && n > 40) begin chk("op_timeout", 0, 1); done = 1; end
        end
      end
    end
    // Operands outside SCAN must be ignored.
    op_val = 1'($urandom); op_act = DW'($urandom); op_wei = DW'($urandom);
    e = (acc <<< (64 - PW)) >>> (64 - PW);
    chk("psum_val", psum_val, 1);
    chk("op_req_in_out", op_req, 0);
    for (int k = 0; k < bp; k++) begin
      chk("bp_psum_val", psum_val, 1);
      chk("bp_psum_data", psum_data, e);
      chk("bp_flg_rdy", flg_rdy, 0);
      chk("bp_op_req", op_req, 0);
      @(negedge clk);
    end
    chk("psum_data", psum_data, e);
    chk("psum_addr", psum_addr, m_addr);
    last_psum = psum_data; last_addr = int'(psum_addr);
    psum_rdy = 1;
    @(negedge clk);
    psum_rdy = 0; op_val = 0;
    m_addr = (m_addr + 1) & ((1 << PAW) - 1);
    m_base = (m_base + $countones(fa)) % 64;
    m_cnt++;
    if (m_cnt == RB) begin
      chk("row_done_hi", row_done, 1);
      chk("row_end_flg_rdy", flg_rdy, 0);
      @(negedge clk);
      chk("row_done_lo", row_done, 0);
      chk("idle_flg_rdy", flg_rdy, 0);
    end else begin
      chk("row_done_mid", row_done, 0);
      chk("flg_rdy_back", flg_rdy, 1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    longint s, oexp;
    int n;
    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst_row_done", row_done, 0);
    chk("rst_flg_rdy", flg_rdy, 0);
    chk("rst_op_req", op_req, 0);
    chk("rst_op_act_addr", op_act_addr, 0);
    chk("rst_op_wei_addr", op_wei_addr, 0);
    chk("rst_psum_val", psum_val, 0);
    chk("rst_psum_addr", psum_addr, 0);
    chk("rst_psum_data", psum_data, 0);
    rst_n = 1;
    @(negedge clk);
    chk("idle_flg_rdy", flg_rdy, 0);

    // Basic block
    start_row(4, 0);
    ops_q = '{3, 5, -2, 7};
    run_block(32'hF, 32'hA, 0, 0);
    chk("basic_req0_act", req_act_q[0], 5);
    chk("basic_req0_wei", req_wei_q[0], 0);
    chk("basic_req1_act", req_act_q[1], 7);
    chk("basic_req1_wei", req_wei_q[1], 1);
    chk("basic_psum", last_psum, 1);
    chk("basic_addr", last_addr, 1);

    // Zero-match block, with backpressure
    run_block(32'h3, 32'hC, 0, 5);
    chk("zero_nreq", req_act_q.size(), 0);
    chk("zero_psum", last_psum, 0);
    run_block(32'h1, 32'h1, 0, 0);
    chk("adv_base", req_act_q[0], 10);

    // Full row, wei_col=2
    start_row(int'($urandom_range(0, 63)), 2);
    chk("row_addr0", psum_addr, 31);
    for (int k = 0; k < RB; k++) begin
      run_block($urandom & $urandom, $urandom | ($urandom & $urandom), 1'($urandom),
                int'($urandom_range(0, 3)));
      chk("row_seq", last_addr, (31 + k) % 32);
    end

    // Abort in SCAN with two matches still pending
    start_row(20, 1);
    flg_val = 1; flg_act = 32'hFF; flg_wei = 32'h0F;
    @(negedge clk);
    flg_val = 0; op_val = 1; op_act = 8'sd1; op_wei = 8'sd1;
    @(negedge clk); @(negedge clk);
    chk("abort_pre_op_req", op_req, 1);
    op_val = 0;
    start_row(9, 0);
    chk("abort_op_req", op_req, 0);
    chk("abort_psum_val", psum_val, 0);
    run_block(32'h6, 32'h4, 0, 0);
    chk("abort_new_base", req_act_q[0], 10);

    // Random row
    start_row(int'($urandom_range(0, 63)), int'($urandom_range(0, 2)));
    for (int k = 0; k < RB; k++)
      run_block($urandom, $urandom, 1'($urandom), int'($urandom_range(0, 2)));

    // Overflow on the narrow instance
    o_row_start = 1;
    @(negedge clk);
    o_row_start = 0; o_flg_val = 1;
    @(negedge clk);
    o_flg_val = 0;
    n = 1;
    while (!o_psum_val && n < 60) begin @(negedge clk); n++; end
    chk("ovf_latency", n, 33);
    s = 32 * 127 * 127;
`ifdef SPARSE_MAC_SAT_EN
    oexp = (s > 32767) ? 32767 : s;
`else
    oexp = (s <<< 48) >>> 48;
`endif
    chk("ovf_psum", o_psum_data, oexp);
    o_psum_rdy = 1;
    @(negedge clk);
    o_psum_rdy = 0;
    chk("ovf_row_done", o_row_done, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
